// File: rtl/ascon_serial_pkg.sv
// Shared definitions for the serial slice datapath: collector FSM encoding and
// the slice-count helper also used by the circular shift register's padding.
package ascon_serial_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } collector_state_e;

    function automatic int num_slices(input int data_width, input int par);
        return (data_width + par - 1) / par;
    endfunction

endpackage

// File: rtl/serial_word_collector.sv
// Reassembles PAR-bit serial slices (LSB slice first) into a DATA_WIDTH-bit word
// and offers it downstream on a valid/ready interface.
module serial_word_collector
    import ascon_serial_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int PAR        = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  slice_valid,
    input  logic [PAR-1:0]        slice_in,
    output logic                  take,
    output logic                  busy,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic [DATA_WIDTH-1:0] word_out
);

    localparam int NUM_SLICES   = num_slices(DATA_WIDTH, PAR);
    localparam int PADDED_WIDTH = NUM_SLICES * PAR;
    localparam int CNT_W        = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

    collector_state_e          state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [PADDED_WIDTH-1:0]   shift_q, shift_d;
    logic                      busy_q, word_valid_q;

    // Next-state, counter, shift register and the combinational take strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        take    = 1'b0;
        if (reset || clear) begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
            shift_d = {PADDED_WIDTH{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = COLLECT;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d = IDLE;
                    end
                end
                COLLECT: begin
                    if (slice_valid) begin
                        take    = 1'b1;
                        // New slice enters at the top; after NUM_SLICES takes
                        // the first slice has reached bit 0.
                        shift_d = shift_q >> PAR;
                        shift_d[PADDED_WIDTH-1 -: PAR] = slice_in;
                        if (cnt_q == LAST_CNT) begin
                            state_d = HOLD;
                            cnt_d   = {CNT_W{1'b0}};
                        end else begin
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = COLLECT;
                    end
                end
                HOLD: begin
                    if (word_ready) begin
                        state_d = start ? COLLECT : IDLE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State register with synchronous reset; status flags registered from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            shift_q      <= {PADDED_WIDTH{1'b0}};
            busy_q       <= 1'b0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            busy_q       <= (state_d != IDLE);
            word_valid_q <= (state_d == HOLD);
        end
    end

    assign busy       = busy_q;
    assign word_valid = word_valid_q;
    // Upstream zero padding sits in the top PADDED_WIDTH-DATA_WIDTH bits and is dropped.
    assign word_out   = shift_q[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed bench: three collector widths fed from rotating upstream register
// models, plus a single-slice instance.
module tb_serial_word_collector;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PAR=1 instance
    logic st1, cl1, sv1, rd1, tk1, bz1, wv1;
    logic [63:0] wo1, csr1, val1;
    logic ld1;
    int ntk1 = 0;

    // PAR=5 instance (65-bit padded source, top bit zero)
    logic st5, cl5, sv5, rd5, tk5, bz5, wv5;
    logic [63:0] wo5;
    logic [64:0] csr5, val5;
    logic ld5;
    int ntk5 = 0;

    // PAR=8 instance
    logic st8, cl8, sv8, rd8, tk8, bz8, wv8;
    logic [63:0] wo8, csr8, val8;
    logic ld8;
    int ntk8 = 0;

    // Single-slice instance: DATA_WIDTH=8, PAR=8
    logic sts, cls, svs, rds, tks, bzs, wvs;
    logic [7:0] sis, wos;

    int errs = 0;
    int nchk = 0;
    int cyc;
    int n0;
    logic [63:0] held;

    serial_word_collector #(.DATA_WIDTH(64), .PAR(1)) u_p1 (
        .clk(clk), .reset(reset), .start(st1), .clear(cl1), .slice_valid(sv1),
        .slice_in(csr1[0:0]), .take(tk1), .busy(bz1), .word_valid(wv1),
        .word_ready(rd1), .word_out(wo1));

    serial_word_collector #(.DATA_WIDTH(64), .PAR(5)) u_p5 (
        .clk(clk), .reset(reset), .start(st5), .clear(cl5), .slice_valid(sv5),
        .slice_in(csr5[4:0]), .take(tk5), .busy(bz5), .word_valid(wv5),
        .word_ready(rd5), .word_out(wo5));

    serial_word_collector #(.DATA_WIDTH(64), .PAR(8)) u_p8 (
        .clk(clk), .reset(reset), .start(st8), .clear(cl8), .slice_valid(sv8),
        .slice_in(csr8[7:0]), .take(tk8), .busy(bz8), .word_valid(wv8),
        .word_ready(rd8), .word_out(wo8));

    serial_word_collector #(.DATA_WIDTH(8), .PAR(8)) u_ps (
        .clk(clk), .reset(reset), .start(sts), .clear(cls), .slice_valid(svs),
        .slice_in(sis), .take(tks), .busy(bzs), .word_valid(wvs),
        .word_ready(rds), .word_out(wos));

    // Upstream circular shift register models: rotate right by PAR on take.
    always @(posedge clk) begin
        if (ld1) csr1 <= val1;
        else if (tk1) csr1 <= {csr1[0], csr1[63:1]};
        if (ld5) csr5 <= val5;
        else if (tk5) csr5 <= {csr5[4:0], csr5[64:5]};
        if (ld8) csr8 <= val8;
        else if (tk8) csr8 <= {csr8[7:0], csr8[63:8]};
        if (tk1) ntk1 <= ntk1 + 1;
        if (tk5) ntk5 <= ntk5 + 1;
        if (tk8) ntk8 <= ntk8 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        {st1, cl1, sv1, rd1, ld1} = 5'b0;
        {st5, cl5, sv5, rd5, ld5} = 5'b0;
        {st8, cl8, sv8, rd8, ld8} = 5'b0;
        {sts, cls, svs, rds} = 4'b0;
        sis = 8'h00;
        val1 = 64'h0; val5 = 65'h0; val8 = 64'h0;
        tick();
        tick();
        chk("reset_busy", {63'd0, bz1}, 64'd0);
        chk("reset_valid", {63'd0, wv1}, 64'd0);
        chk("reset_word", wo1, 64'd0);
        chk("reset_take", {63'd0, tk1}, 64'd0);
        chk("reset_word_p5", wo5, 64'd0);
        reset = 1'b0;

        // PAR=1 full word, slice_valid held high
        val1 = 64'h0123456789ABCDEF; ld1 = 1'b1;
        val5 = {1'b0, 64'hFEDCBA9876543210}; ld5 = 1'b1;
        val8 = 64'h0F1E2D3C4B5A6978; ld8 = 1'b1;
        tick();
        ld1 = 1'b0; ld5 = 1'b0; ld8 = 1'b0;
        chk("idle_take", {63'd0, tk1}, 64'd0);
        n0 = ntk1;
        st1 = 1'b1; sv1 = 1'b1;
        tick();
        st1 = 1'b0;
        cyc = 1;
        chk("p1_busy_collect", {63'd0, bz1}, 64'd1);
        while (!wv1 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("p1_latency", 64'(cyc), 64'd65);
        chk("p1_word", wo1, 64'h0123456789ABCDEF);
        chk("p1_csr_restored", csr1, 64'h0123456789ABCDEF);
        chk("p1_takes", 64'(ntk1 - n0), 64'd64);
        chk("p1_hold_take", {63'd0, tk1}, 64'd0);
        rd1 = 1'b1;
        tick();
        rd1 = 1'b0;
        chk("p1_after_hs_busy", {63'd0, bz1}, 64'd0);
        chk("p1_after_hs_valid", {63'd0, wv1}, 64'd0);

        // PAR=1 clear after 20 takes, then a fresh word
        n0 = ntk1;
        st1 = 1'b1;
        tick();
        st1 = 1'b0;
        repeat (20) tick();
        chk("p1_pre_clear_takes", 64'(ntk1 - n0), 64'd20);
        cl1 = 1'b1;
        #1;
        chk("clear_take", {63'd0, tk1}, 64'd0);
        tick();
        cl1 = 1'b0;
        chk("clear_busy", {63'd0, bz1}, 64'd0);
        chk("clear_valid", {63'd0, wv1}, 64'd0);
        chk("clear_word", wo1, 64'd0);
        chk("clear_idle_take", {63'd0, tk1}, 64'd0);
        val1 = 64'hA5A55A5ADEADBEEF; ld1 = 1'b1;
        tick();
        ld1 = 1'b0;
        st1 = 1'b1;
        tick();
        st1 = 1'b0;
        cyc = 1;
        while (!wv1 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("p1_second_latency", 64'(cyc), 64'd65);
        chk("p1_second_word", wo1, 64'hA5A55A5ADEADBEEF);

        // PAR=5: 13 slices, one pad bit
        n0 = ntk5;
        st5 = 1'b1; sv5 = 1'b1;
        tick();
        st5 = 1'b0;
        cyc = 1;
        while (!wv5 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("p5_latency", 64'(cyc), 64'd14);
        chk("p5_takes", 64'(ntk5 - n0), 64'd13);
        chk("p5_word", wo5, 64'hFEDCBA9876543210);

        // PAR=8 with slice_valid pattern 1,0,0,1,0,0,...
        n0 = ntk8;
        st8 = 1'b1; sv8 = 1'b0;
        tick();
        st8 = 1'b0;
        cyc = 1;
        while (!wv8 && cyc < 200) begin
            sv8 = ((cyc - 1) % 3 == 0);
            #1;
            chk("p8_take_follows_valid", {63'd0, tk8}, {63'd0, sv8});
            tick();
            cyc++;
        end
        sv8 = 1'b0;
        chk("p8_latency", 64'(cyc), 64'd23);
        chk("p8_takes", 64'(ntk8 - n0), 64'd8);
        chk("p8_word", wo8, 64'h0F1E2D3C4B5A6978);

        // HOLD stall: word must stay put, start ignored without handshake
        held = 64'h0F1E2D3C4B5A6978;
        for (int i = 0; i < 10; i++) begin
            st8 = (i == 3);
            tick();
            chk("stall_valid", {63'd0, wv8}, 64'd1);
            chk("stall_word", wo8, held);
            chk("stall_take", {63'd0, tk8}, 64'd0);
        end
        st8 = 1'b1; rd8 = 1'b1;
        tick();
        st8 = 1'b0; rd8 = 1'b0;
        chk("hs_start_busy", {63'd0, bz8}, 64'd1);
        chk("hs_start_valid", {63'd0, wv8}, 64'd0);
        sv8 = 1'b1;
        #1;
        chk("hs_start_collect_take", {63'd0, tk8}, 64'd1);
        sv8 = 1'b0;

        // Single-slice configuration
        sts = 1'b1; svs = 1'b1; sis = 8'h3C;
        tick();
        sts = 1'b0;
        cyc = 1;
        chk("single_take", {63'd0, tks}, 64'd1);
        while (!wvs && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("single_latency", 64'(cyc), 64'd2);
        chk("single_word", {56'd0, wos}, 64'h3C);

        // Reset in HOLD concurrent with word_ready and start
        chk("p1_in_hold", {63'd0, wv1}, 64'd1);
        rd1 = 1'b1; st1 = 1'b1; sv1 = 1'b1;
        reset = 1'b1;
        tick();
        chk("rst_busy", {63'd0, bz1}, 64'd0);
        chk("rst_valid", {63'd0, wv1}, 64'd0);
        chk("rst_word", wo1, 64'd0);
        chk("rst_take", {63'd0, tk1}, 64'd0);
        reset = 1'b0; st1 = 1'b0; rd1 = 1'b0;
        tick();
        chk("rst_no_handshake_start", {63'd0, bz1}, 64'd0);
        chk("rst_idle_take", {63'd0, tk1}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
